luma_packetizer: RTL



---
 rtl/sobel_pkg.sv | 19 +
 rtl/packetizer_stats.sv | 23 ++
 rtl/luma_packetizer.sv | 96 +++++++++
 3 files changed

// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel return path: packet beat layout,
// packet geometry and the packetizer state encoding.
package sobel_pkg;

  localparam int PCIE_DATA_W      = 512;
  localparam int BYTES_PER_PACKET = 64;
  localparam logic [5:0] IDX_MAX  = 6'd63;

  typedef struct packed {
    logic                   valid;
    logic [PCIE_DATA_W-1:0] data;
  } PCIEPacket;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_SEND = 1'b1
  } pkt_state_e;

endpackage

// File: rtl/packetizer_stats.sv
// Packet and frame counters for the return-path packetizer. Both wrap on
// overflow and count only completed PCIe handshakes.
module packetizer_stats (
  input  logic        clk,
  input  logic        rst,
  input  logic        pkt_hs,
  input  logic        pkt_hs_last,
  output logic [31:0] pkt_count,
  output logic [15:0] frame_count
);

  // Count every accepted packet, and every accepted frame-closing packet.
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_count   <= '0;
      frame_count <= '0;
    end else if (pkt_hs) begin
      pkt_count <= pkt_count + 32'd1;
      if (pkt_hs_last) frame_count <= frame_count + 16'd1;
    end
  end

endmodule

// File: rtl/luma_packetizer.sv
// Packs 8-bit luma pixels into 512-bit PCIe beats, little-endian byte order,
// flushing a zero-padded short packet on frame end.
// Optional feature: define LUMA_PACKETIZER_STATS_EN to add pkt_count and
// frame_count outputs.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_FILL | accepting pixels into the buffer; no packet offered
// ST_SEND | packet offered on pcie_packet_out; pixels held off until taken
module luma_packetizer #(
  parameter int BYTES_PER_PACKET = sobel_pkg::BYTES_PER_PACKET
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pixel_valid,
  input  logic [7:0]           pixel_data,
  input  logic                 pixel_last,
  output logic                 pixel_ready,
  output sobel_pkg::PCIEPacket pcie_packet_out,
  input  logic                 pcie_ready,
  output logic                 pcie_last,
  output logic [6:0]           pcie_bytes
`ifdef LUMA_PACKETIZER_STATS_EN
  ,
  output logic [31:0]          pkt_count,
  output logic [15:0]          frame_count
`endif
);
  import sobel_pkg::*;

  // The byte index and buffer layout are sized for one byte per data lane.
  if (BYTES_PER_PACKET != PCIE_DATA_W / 8) begin : g_bad_geometry
    $error("BYTES_PER_PACKET must equal PCIE_DATA_W/8");
  end

  pkt_state_e             state;
  logic [5:0]             idx;
  logic [PCIE_DATA_W-1:0] data_q;
  logic                   valid_q;
  logic                   pkt_hs;

  assign pixel_ready           = (state == ST_FILL);
  assign pcie_packet_out.valid = valid_q;
  assign pcie_packet_out.data  = data_q;
  assign pkt_hs                = (state == ST_SEND) && pcie_ready;

  // Fill/send sequencing; the buffer is cleared on hand-off so short
  // packets read as zero beyond their last written byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_FILL;
      idx        <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      pcie_last  <= 1'b0;
      pcie_bytes <= '0;
    end else begin
      case (state)
        ST_FILL: begin
          if (pixel_valid) begin
            data_q[{idx, 3'b000} +: 8] <= pixel_data;
            idx                        <= idx + 6'd1;
            if (idx == IDX_MAX || pixel_last) begin
              state      <= ST_SEND;
              valid_q    <= 1'b1;
              pcie_bytes <= {1'b0, idx} + 7'd1;
              pcie_last  <= pixel_last;
            end
          end
        end
        ST_SEND: begin
          if (pcie_ready) begin
            state     <= ST_FILL;
            valid_q   <= 1'b0;
            data_q    <= '0;
            idx       <= '0;
            pcie_last <= 1'b0;
          end
        end
        default: state <= ST_FILL;
      endcase
    end
  end

`ifdef LUMA_PACKETIZER_STATS_EN
  packetizer_stats u_stats (
    .clk         (clk),
    .rst         (rst),
    .pkt_hs      (pkt_hs),
    .pkt_hs_last (pcie_last),
    .pkt_count   (pkt_count),
    .frame_count (frame_count)
  );
`endif

endmodule
